// File: rtl/reg_bus_xfer_ctrl.sv
// Register-to-register move sequencer for the shared 16-bit bus of the 4x16 register bank.
// Arbitrates bus ownership between internal moves and one external master.
module reg_bus_xfer_ctrl #(
    parameter int unsigned TURNAROUND = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_SRC,
    input  logic [1:0] CMD_DST,
    input  logic       EXT_REQ,
    output logic       EXT_GNT,
    input  logic       EXT_DONE,
    output logic [1:0] SEL,
    output logic       BUS_OE,
    output logic [3:0] LOAD,
    output logic       XFER_DONE,
    output logic       BUSY
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StDrive   = 3'd1;
    localparam logic [2:0] StLoad    = 3'd2;
    localparam logic [2:0] StTurn    = 3'd3;
    localparam logic [2:0] StExtOwn  = 3'd4;
    localparam logic [2:0] StExtTurn = 3'd5;

    localparam logic [2:0] TurnInit = 3'(TURNAROUND - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] src_q, src_d;
    logic [1:0] dst_q, dst_d;
    logic [2:0] cnt_q, cnt_d;
    logic       prio_ext_q, prio_ext_d;
    logic       done_q, done_d;

    logic int_win;
    logic ext_win;
    logic is_idle;

    // prio_ext_q set means the external master wins a simultaneous request.
    always_comb begin
        int_win = CMD_VALID && (!EXT_REQ || !prio_ext_q);
        ext_win = EXT_REQ && (!CMD_VALID || prio_ext_q);
        is_idle = (state_q == StIdle);
    end

    // The only combinational output; gated so it is low throughout reset.
    always_comb begin
        CMD_READY = RST_N && is_idle && int_win;
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        prio_ext_d = prio_ext_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (int_win) begin
                    src_d = CMD_SRC;
                    dst_d = CMD_DST;
                    if (CMD_SRC == CMD_DST) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StDrive;
                    end
                    if (EXT_REQ) begin
                        prio_ext_d = 1'b1;
                    end
                end else if (ext_win) begin
                    state_d = StExtOwn;
                    if (CMD_VALID) begin
                        prio_ext_d = 1'b0;
                    end
                end
            end
            StDrive: begin
                state_d = StLoad;
            end
            StLoad: begin
                state_d = StTurn;
                cnt_d   = TurnInit;
                done_d  = 1'b1;
            end
            StTurn: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StExtOwn: begin
                if (EXT_DONE || !EXT_REQ) begin
                    state_d = StExtTurn;
                    cnt_d   = TurnInit;
                end
            end
            StExtTurn: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            src_q      <= 2'd0;
            dst_q      <= 2'd0;
            cnt_q      <= 3'd0;
            prio_ext_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            prio_ext_q <= prio_ext_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        SEL       = src_q;
        BUS_OE    = (state_q == StDrive) || (state_q == StLoad);
        LOAD      = (state_q == StLoad) ? (4'b0001 << dst_q) : 4'b0000;
        EXT_GNT   = (state_q == StExtOwn);
        XFER_DONE = done_q;
        BUSY      = !is_idle;
    end

endmodule

// File: tb/tb_reg_bus_xfer_ctrl.sv
// Bench for reg_bus_xfer_ctrl: two instances (TURNAROUND 1 and 3) share stimulus and are
// compared every cycle against a timeline model of moves and external ownership.
module tb_reg_bus_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_src;
    logic [1:0] cmd_dst;
    logic       ext_req;
    logic       ext_done;

    logic       ready_w [2];
    logic       gnt_w   [2];
    logic       oe_w    [2];
    logic       done_w  [2];
    logic       busy_w  [2];
    logic [1:0] sel_w   [2];
    logic [3:0] load_w  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 idle, 1 move timeline, 2 external owner, 3 external turnaround.
    int         m_kind     [2];
    int         m_pos      [2];
    logic [1:0] m_src      [2];
    logic [1:0] m_dst      [2];
    bit         m_prio_ext [2];
    bit         m_null_done[2];

    always #5 clk = ~clk;

    reg_bus_xfer_ctrl #(.TURNAROUND(1)) dut_t1 (
        .CLK(clk), .RST_N(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(ready_w[0]),
        .CMD_SRC(cmd_src), .CMD_DST(cmd_dst), .EXT_REQ(ext_req), .EXT_GNT(gnt_w[0]),
        .EXT_DONE(ext_done), .SEL(sel_w[0]), .BUS_OE(oe_w[0]), .LOAD(load_w[0]),
        .XFER_DONE(done_w[0]), .BUSY(busy_w[0])
    );

    reg_bus_xfer_ctrl #(.TURNAROUND(3)) dut_t3 (
        .CLK(clk), .RST_N(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(ready_w[1]),
        .CMD_SRC(cmd_src), .CMD_DST(cmd_dst), .EXT_REQ(ext_req), .EXT_GNT(gnt_w[1]),
        .EXT_DONE(ext_done), .SEL(sel_w[1]), .BUS_OE(oe_w[1]), .LOAD(load_w[1]),
        .XFER_DONE(done_w[1]), .BUSY(busy_w[1])
    );

    function automatic int ta(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_kind[i]      = 0;
            m_pos[i]       = 0;
            m_src[i]       = 2'd0;
            m_dst[i]       = 2'd0;
            m_prio_ext[i]  = 1'b0;
            m_null_done[i] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic       e_oe, e_gnt, e_busy, e_done, e_ready, chk_sel;
            logic [3:0] e_load;
            string      t;
            t       = $sformatf("[T=%0d]", ta(i));
            e_oe    = 1'b0;
            e_gnt   = 1'b0;
            e_busy  = (m_kind[i] != 0);
            e_done  = 1'b0;
            e_load  = 4'b0000;
            chk_sel = 1'b0;
            e_ready = (m_kind[i] == 0) && cmd_valid && (!ext_req || !m_prio_ext[i]);
            case (m_kind[i])
                0: e_done = m_null_done[i];
                1: begin
                    chk_sel = 1'b1;
                    e_oe    = (m_pos[i] < 2);
                    e_done  = (m_pos[i] == 2);
                    if (m_pos[i] == 1) e_load = 4'(1 << m_dst[i]);
                end
                2: e_gnt = 1'b1;
                default: ;
            endcase
            check_eq({"cmd_ready", t}, 32'(ready_w[i]), 32'(e_ready));
            check_eq({"bus_oe", t}, 32'(oe_w[i]), 32'(e_oe));
            check_eq({"ext_gnt", t}, 32'(gnt_w[i]), 32'(e_gnt));
            check_eq({"load", t}, 32'(load_w[i]), 32'(e_load));
            check_eq({"xfer_done", t}, 32'(done_w[i]), 32'(e_done));
            check_eq({"busy", t}, 32'(busy_w[i]), 32'(e_busy));
            check_eq({"no_overlap", t}, 32'(oe_w[i] & gnt_w[i]), 32'd0);
            if (chk_sel) check_eq({"sel", t}, 32'(sel_w[i]), 32'(m_src[i]));
        end
    endtask

    task automatic model_advance();
        for (int i = 0; i < 2; i++) begin
            bit iw, ew;
            m_null_done[i] = 1'b0;
            case (m_kind[i])
                0: begin
                    iw = cmd_valid && (!ext_req || !m_prio_ext[i]);
                    ew = ext_req && (!cmd_valid || m_prio_ext[i]);
                    if (cmd_valid && ext_req) m_prio_ext[i] = iw;
                    if (iw) begin
                        m_src[i] = cmd_src;
                        m_dst[i] = cmd_dst;
                        if (cmd_src == cmd_dst) begin
                            m_null_done[i] = 1'b1;
                        end else begin
                            m_kind[i] = 1;
                            m_pos[i]  = 0;
                        end
                    end else if (ew) begin
                        m_kind[i] = 2;
                    end
                end
                1: begin
                    m_pos[i]++;
                    if (m_pos[i] == 2 + ta(i)) m_kind[i] = 0;
                end
                2: begin
                    if (ext_done || !ext_req) begin
                        m_kind[i] = 3;
                        m_pos[i]  = 0;
                    end
                end
                default: begin
                    m_pos[i]++;
                    if (m_pos[i] == ta(i)) m_kind[i] = 0;
                end
            endcase
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            string t;
            t = $sformatf("%s[T=%0d]", tag, ta(i));
            check_eq({t, "_ready"}, 32'(ready_w[i]), 32'd0);
            check_eq({t, "_oe"}, 32'(oe_w[i]), 32'd0);
            check_eq({t, "_gnt"}, 32'(gnt_w[i]), 32'd0);
            check_eq({t, "_load"}, 32'(load_w[i]), 32'd0);
            check_eq({t, "_done"}, 32'(done_w[i]), 32'd0);
            check_eq({t, "_busy"}, 32'(busy_w[i]), 32'd0);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [1:0] s, input logic [1:0] d,
                        input logic rq, input logic dn);
        cmd_valid = v;
        cmd_src   = s;
        cmd_dst   = d;
        ext_req   = rq;
        ext_done  = dn;
        #1;
        check_outputs();
        model_advance();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_src   = 2'd1;
        cmd_dst   = 2'd2;
        ext_req   = 1'b1;
        ext_done  = 1'b0;
        model_reset();
        #3;
        check_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Move 2->0 held valid across completion.
        repeat (8) step(1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Null move.
        step(1'b1, 2'd3, 2'd3, 1'b0, 1'b0);
        repeat (3) step(1'b0, 2'd3, 2'd3, 1'b0, 1'b0);

        // Simultaneous requests: grants alternate.
        for (int k = 0; k < 40; k++) step(1'b1, 2'd0, 2'd3, 1'b1, (k % 4) == 3);
        repeat (8) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        // External alone, release after 5 cycles, with a command pending behind it.
        step(1'b0, 2'd1, 2'd2, 1'b1, 1'b0);
        repeat (4) step(1'b1, 2'd1, 2'd2, 1'b1, 1'b0);
        step(1'b1, 2'd1, 2'd2, 1'b1, 1'b1);
        repeat (6) step(1'b1, 2'd1, 2'd2, 1'b0, 1'b0);
        repeat (8) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Back-to-back moves 0->1 then 1->2.
        step(1'b1, 2'd0, 2'd1, 1'b0, 1'b0);
        repeat (6) step(1'b1, 2'd1, 2'd2, 1'b0, 1'b0);
        repeat (8) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Reset during the LOAD cycle of move 1->3.
        step(1'b1, 2'd1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        #1;
        check_outputs();
        #2;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        check_zero("held_reset");
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 2'd0, 2'd0, 1'b1, 1'b1);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            step(($urandom % 4) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 ($urandom % 3) == 0, ($urandom % 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
